// File: rtl/vga_mon_pkg.sv
// Shared constants and types for the VGA stream monitor: default mode geometry,
// CRC-16-CCITT parameters, error flag bit positions and FSM encoding.
package vga_mon_pkg;
  localparam int H_TOTAL_DEF     = 1328;
  localparam int H_ACTIVE_DEF    = 1024;
  localparam int V_TOTAL_DEF     = 806;
  localparam int V_ACTIVE_DEF    = 768;
  localparam int LOCK_FRAMES_DEF = 2;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [10:0] CNT_MAX  = 11'h7FF;

  localparam int ERR_LINE  = 0;
  localparam int ERR_PX    = 1;
  localparam int ERR_FRAME = 2;
  localparam int ERR_VACT  = 3;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_t;
endpackage

// File: rtl/vga_stream_monitor_if.sv
// Tapped video stream bundle: syncs, blanks and 12-bit {r,g,b} pixel.
interface vga_stream_monitor_if;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;

  modport master (output hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in);
  modport slave  (input  hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in);
endinterface

// File: rtl/crc16_ccitt_12.sv
// One-pixel step of CRC-16-CCITT (poly 0x1021, unreflected), 12 data bits MSB first.
module crc16_ccitt_12
  import vga_mon_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [11:0] data,
  output logic [15:0] crc_out
);
  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 11; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? CRC_POLY : 16'h0000);
    end
    crc_out = c;
  end
endmodule

// File: rtl/vga_stream_monitor.sv
// Receive-side checker for the output pixel stream: measures line/frame geometry,
// locks after consecutive conforming frames and signs each frame with a CRC.
module vga_stream_monitor
  import vga_mon_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic                 pclk,
  input  logic                 rst,
  vga_stream_monitor_if.slave  vid,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 frame_done,
  output logic [15:0]          frame_crc,
  output logic [10:0]          h_total_meas,
  output logic [10:0]          v_total_meas,
  output logic [3:0]           err_flags
);
  localparam logic [10:0] HT     = 11'(H_TOTAL);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VT     = 11'(V_TOTAL);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [4:0]  LOCK_N = 5'(LOCK_FRAMES);

  logic        hs_d, vs_d, hs_edge, vs_edge, px_act;
  logic [10:0] h_cnt, px_cnt, v_cnt, act_lines, h_len;
  logic        len_bad, px_bad, line_bad, frame_bad, frame_ok, h_lost, chk_en;
  logic [15:0] crc_q, crc_nx;
  logic [3:0]  good_cnt, good_n, err_set;
  mon_state_t  state, state_n;

  assign hs_edge  = vid.hsync_in & ~hs_d;
  assign vs_edge  = vid.vsync_in & ~vs_d;
  assign px_act   = ~vid.hblnk_in & ~vid.vblnk_in;
  assign h_lost   = (h_cnt == CNT_MAX);
  assign h_len    = h_lost ? CNT_MAX : h_cnt + 11'd1;
  assign len_bad  = (h_len != HT);
  assign px_bad   = (px_cnt != 11'd0) && (px_cnt != HA);
  assign line_bad = hs_edge & (len_bad | px_bad);
  assign frame_ok = ~frame_bad && (v_cnt == VT) && (act_lines == VA);
  assign chk_en   = (state != ST_SEARCH);
  assign locked   = (state == ST_LOCKED);

  crc16_ccitt_12 u_crc (.crc_in(crc_q), .data(vid.rgb_in), .crc_out(crc_nx));

  // Errors only count once we have seen a frame start; before that the line is partial.
  always_comb begin
    err_set = '0;
    if (chk_en) begin
      err_set[ERR_LINE]  = (hs_edge & len_bad) | h_lost;
      err_set[ERR_PX]    = hs_edge & px_bad;
      err_set[ERR_FRAME] = vs_edge & (v_cnt != VT);
      err_set[ERR_VACT]  = vs_edge & (act_lines != VA);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hs_d <= 1'b0; vs_d <= 1'b0;
      h_cnt <= '0; px_cnt <= '0; v_cnt <= '0; act_lines <= '0;
      frame_bad <= 1'b0; crc_q <= CRC_INIT;
      frame_done <= 1'b0; frame_crc <= '0;
      h_total_meas <= '0; v_total_meas <= '0; err_flags <= '0;
    end else begin
      hs_d <= vid.hsync_in;
      vs_d <= vid.vsync_in;
      frame_done <= 1'b0;
      if (hs_edge) begin
        h_cnt        <= '0;
        h_total_meas <= h_len;
      end else if (!h_lost) h_cnt <= h_cnt + 11'd1;
      if (hs_edge) px_cnt <= '0;
      else if (px_act && px_cnt != CNT_MAX) px_cnt <= px_cnt + 11'd1;
      // A line closed on the vsync edge itself is counted in the new frame.
      if (vs_edge) begin
        v_cnt     <= {10'd0, hs_edge};
        act_lines <= {10'd0, hs_edge && px_cnt != 11'd0};
        frame_bad <= line_bad;
        crc_q     <= CRC_INIT;
        if (chk_en) begin
          frame_done   <= 1'b1;
          frame_crc    <= crc_q;
          v_total_meas <= v_cnt;
        end
      end else begin
        if (hs_edge && v_cnt != CNT_MAX) v_cnt <= v_cnt + 11'd1;
        if (hs_edge && px_cnt != 11'd0 && act_lines != CNT_MAX) act_lines <= act_lines + 11'd1;
        if (line_bad) frame_bad <= 1'b1;
        if (px_act) crc_q <= crc_nx;
      end
      err_flags <= (err_clr ? 4'b0000 : err_flags) | err_set;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_n;
      good_cnt <= good_n;
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    case (state)
      ST_SEARCH: if (vs_edge) begin
        state_n = ST_MEASURE;
        good_n  = '0;
      end
      ST_MEASURE: if (vs_edge) begin
        if (!frame_ok) good_n = '0;
        else if ({1'b0, good_cnt} + 5'd1 >= LOCK_N) begin
          state_n = ST_LOCKED;
          good_n  = '0;
        end else good_n = good_cnt + 4'd1;
      end
      ST_LOCKED: if (line_bad || (vs_edge && !frame_ok)) state_n = ST_SEARCH;
      default: state_n = ST_SEARCH;
    endcase
    if (h_lost) state_n = ST_SEARCH;
  end
endmodule

// File: tb/tb_vga_stream_monitor.sv
// Directed bench for vga_stream_monitor using a reduced 20x10 geometry
// (12 active px, 6 active lines, hsync at x=14..15, vsync on lines 7..8).
module tb_vga_stream_monitor;
  localparam int HT  = 20;
  localparam int HA  = 12;
  localparam int VT  = 10;
  localparam int VA  = 6;
  localparam int LF  = 2;
  localparam int HS0 = 14;

  logic        pclk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic        locked, frame_done;
  logic [15:0] frame_crc;
  logic [10:0] h_total_meas, v_total_meas;
  logic [3:0]  err_flags;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int last_lock = 0;

  vga_stream_monitor_if vif ();

  vga_stream_monitor #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .pclk(pclk), .rst(rst), .vid(vif.slave), .err_clr(err_clr),
    .locked(locked), .frame_done(frame_done), .frame_crc(frame_crc),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas), .err_flags(err_flags)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_px(input logic [15:0] c_in, input logic [11:0] d);
    logic [15:0] c;
    logic fb;
    c = c_in;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc_frame(input logic [11:0] p00);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < VA * HA; k++) c = crc_px(c, (k == 0) ? p00 : 12'h000);
    return c;
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
    if (frame_done === 1'b1) begin
      done_cnt++;
      last_lock = int'(locked);
    end
  endtask

  task automatic idle(input int n);
    vif.hsync_in = 1'b0; vif.vsync_in = 1'b0;
    vif.hblnk_in = 1'b1; vif.vblnk_in = 1'b1;
    vif.rgb_in = 12'h000; err_clr = 1'b0;
    repeat (n) step();
  endtask

  // st_y: line stretched by one cycle; dr_y: line missing pixel x=5;
  // clr_y: line whose hsync edge cycle carries err_clr; last_y: last line sent.
  task automatic frame(input int st_y, input int dr_y, input int clr_y,
                       input int last_y, input logic [11:0] p00);
    for (int y = 0; y <= last_y; y++) begin
      for (int x = 0; x < ((y == st_y) ? HT + 1 : HT); x++) begin
        vif.hsync_in = (x == HS0) || (x == HS0 + 1);
        vif.vsync_in = (y == 7) || (y == 8);
        vif.hblnk_in = (x >= HA) || (y == dr_y && x == 5);
        vif.vblnk_in = (y >= VA);
        vif.rgb_in   = (y == 0 && x == 0) ? p00 : 12'h000;
        err_clr      = (y == clr_y) && (x == HS0);
        step();
      end
    end
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle(3);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_crc", 32'(frame_crc), 0);
    chk("rst_hmeas", 32'(h_total_meas), 0);
    chk("rst_vmeas", 32'(v_total_meas), 0);
    chk("rst_err", 32'(err_flags), 0);
    rst = 1'b0;

    // three clean frames: first vsync only arms measurement
    done_cnt = 0;
    repeat (3) frame(-1, -1, -1, VT - 1, 12'h000);
    chk("lock_done_cnt", done_cnt, 2);
    chk("lock_at_pulse", last_lock, 1);
    chk("lock_locked", 32'(locked), 1);
    chk("lock_hmeas", 32'(h_total_meas), HT);
    chk("lock_vmeas", 32'(v_total_meas), VT);
    chk("lock_err", 32'(err_flags), 0);
    chk("crc_zero", 32'(frame_crc), 32'(crc_frame(12'h000)));

    // single red pixel at (0,0), twice
    done_cnt = 0;
    frame(-1, -1, -1, VT - 1, 12'hF00);
    chk("crc_px1", 32'(frame_crc), 32'(crc_frame(12'hF00)));
    frame(-1, -1, -1, VT - 1, 12'hF00);
    chk("crc_px2", 32'(frame_crc), 32'(crc_frame(12'hF00)));
    chk("crc_done_cnt", done_cnt, 2);
    chk("crc_locked", 32'(locked), 1);

    // stretched line while locked
    done_cnt = 0;
    frame(2, -1, -1, VT - 1, 12'h000);
    chk("st_err", 32'(err_flags), 1);
    chk("st_locked", 32'(locked), 0);
    chk("st_done", done_cnt, 0);
    chk("st_hmeas", 32'(h_total_meas), HT);
    frame(-1, -1, -1, VT - 1, 12'h000);
    chk("st_relock1", 32'(locked), 0);
    chk("st_done1", done_cnt, 1);
    frame(-1, -1, -1, VT - 1, 12'h000);
    chk("st_relock2", 32'(locked), 1);
    chk("st_done2", done_cnt, 2);
    chk("st_err_sticky", 32'(err_flags), 1);
    frame(-1, -1, 0, VT - 1, 12'h000);
    chk("st_err_clr", 32'(err_flags), 0);
    chk("st_still_locked", 32'(locked), 1);

    // dropped pixel on an active line
    done_cnt = 0;
    frame(-1, 3, -1, VT - 1, 12'h000);
    chk("dr_err", 32'(err_flags), 2);
    chk("dr_locked", 32'(locked), 0);
    chk("dr_done", done_cnt, 0);
    frame(-1, -1, 0, VT - 1, 12'h000);
    chk("dr_err_clr", 32'(err_flags), 0);
    chk("dr_measure_done", done_cnt, 1);
    chk("dr_vmeas", 32'(v_total_meas), VT);

    // hsync lost long enough to saturate the line counter
    idle(2100);
    chk("lost_err", 32'(err_flags), 1);
    chk("lost_locked", 32'(locked), 0);
    done_cnt = 0;
    frame(-1, -1, -1, VT - 1, 12'h000);
    chk("lost_no_done", done_cnt, 0);
    chk("lost_hmeas", 32'(h_total_meas), HT);

    // reset mid-frame
    frame(-1, -1, -1, 3, 12'h000);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_done", 32'(frame_done), 0);
    chk("mid_rst_crc", 32'(frame_crc), 0);
    chk("mid_rst_hmeas", 32'(h_total_meas), 0);
    chk("mid_rst_vmeas", 32'(v_total_meas), 0);
    chk("mid_rst_err", 32'(err_flags), 0);
    rst = 1'b0;

    // new error and err_clr in the same cycle: the error wins
    done_cnt = 0;
    frame(-1, -1, -1, VT - 1, 12'h000);
    chk("post_rst_no_done", done_cnt, 0);
    frame(2, -1, 3, VT - 1, 12'h000);
    chk("clr_vs_set_err", 32'(err_flags), 1);
    chk("clr_vs_set_done", done_cnt, 1);
    chk("clr_vs_set_locked", 32'(locked), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
